// File: rtl/ram_pipelined_if.sv
// ram_pipelined_if: request/response bus between a memory client and ram_pipelined
//   master: drives req_valid/req_we/req_addr/req_be/req_wdata and rsp_ready
//   slave : drives req_ready and rsp_valid/rsp_rdata/rsp_we/rsp_err
interface ram_pipelined_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W/8-1:0]   req_be;
   logic [DATA_W-1:0]     req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_we;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
   );
endinterface

// File: rtl/ram_pipelined.sv
// ram_pipelined: pipelined byte-lane data memory with valid/ready request and response channels
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset (clears the response FIFO, keeps the array)
//   bus   : slave side of ram_pipelined_if
//           req_*  : request (we, byte address, byte enables, write data) with valid/ready
//           rsp_*  : in-order response (rdata, we echo, out-of-range error) with valid/ready
module ram_pipelined #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int DEPTH          = 32768,
   parameter int RSP_DEPTH      = 2,
   parameter int WRITE_RSP_DATA = 0
) (
   input logic            clk,
   input logic            rst_n,
   ram_pipelined_if.slave bus
);
   localparam int NB = DATA_W / 8;
   localparam int BL = $clog2(NB);
   localparam int IW = ADDR_W - BL;
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(RSP_DEPTH);

   logic [IW-1:0]     idx;
   logic [AW-1:0]     widx;
   logic              err;
   logic              accept;
   logic              pop;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] push_data;

   logic [DATA_W-1:0]    data_q [RSP_DEPTH];
   logic [RSP_DEPTH-1:0] we_q;
   logic [RSP_DEPTH-1:0] err_q;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;

   assign idx  = bus.req_addr[ADDR_W-1:BL];
   assign widx = idx[AW-1:0];
   // compared at 64 bits so DEPTH never gets truncated to the index width
   assign err  = 64'(idx) >= 64'(DEPTH);

   // ready only looks at registered occupancy; gating with rst_n keeps requests
   // presented during reset from being accepted or writing the array
   assign bus.req_ready = rst_n && (count_q < CNT_FULL);
   assign accept        = bus.req_valid && bus.req_ready;
   assign bus.rsp_valid = count_q != '0;
   assign pop           = bus.rsp_valid && bus.rsp_ready;

   // one byte-wide array per lane; the read is taken before the same-edge write
   for (genvar l = 0; l < NB; l++) begin : g_lane
      logic [7:0] mem_q [DEPTH];
      always_ff @(posedge clk) begin
         if (accept && bus.req_we && !err && bus.req_be[l])
            mem_q[widx] <= bus.req_wdata[8*l +: 8];
      end
      assign rd_word[8*l +: 8] = mem_q[widx];
   end

   assign push_data = (err || (bus.req_we && WRITE_RSP_DATA == 0)) ? '0 : rd_word;

   always_comb begin
      wr_ptr_d = accept ? (wr_ptr_q == PTR_LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d = pop ? (rd_ptr_q == PTR_LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      count_d  = count_q + CW'(accept) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // entry storage needs no reset: outputs are masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (accept) begin
         data_q[wr_ptr_q] <= push_data;
         we_q[wr_ptr_q]   <= bus.req_we;
         err_q[wr_ptr_q]  <= err;
      end
   end

   assign bus.rsp_rdata = bus.rsp_valid ? data_q[rd_ptr_q] : '0;
   assign bus.rsp_we    = bus.rsp_valid && we_q[rd_ptr_q];
   assign bus.rsp_err   = bus.rsp_valid && err_q[rd_ptr_q];

   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_FULL);
   a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
      bus.rsp_valid && !bus.rsp_ready |=> bus.rsp_valid && $stable(bus.rsp_rdata));
endmodule

// File: tb/tb_ram_pipelined.sv
// tb_ram_pipelined: scoreboard bench driving a plain and a swap-mode ram_pipelined in lockstep
module tb_ram_pipelined;
   typedef struct packed {
      logic        we;
      logic        err;
      logic [31:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [3:0]  req_be = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;
   int          n_chk = 0;
   int          n_fail = 0;
   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] model [1024];

   always #5 clk = ~clk;

   ram_pipelined_if #(.DATA_W(32), .ADDR_W(32)) b0 ();
   ram_pipelined_if #(.DATA_W(32), .ADDR_W(32)) b1 ();

   assign b0.req_valid = req_valid;
   assign b0.req_we    = req_we;
   assign b0.req_addr  = req_addr;
   assign b0.req_be    = req_be;
   assign b0.req_wdata = req_wdata;
   assign b0.rsp_ready = rsp_ready;
   assign b1.req_valid = req_valid;
   assign b1.req_we    = req_we;
   assign b1.req_addr  = req_addr;
   assign b1.req_be    = req_be;
   assign b1.req_wdata = req_wdata;
   assign b1.rsp_ready = rsp_ready;

   ram_pipelined #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .RSP_DEPTH(2), .WRITE_RSP_DATA(0))
      u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   ram_pipelined #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .RSP_DEPTH(2), .WRITE_RSP_DATA(1))
      u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

   // accepted request -> expected responses for both modes, model updated afterwards
   always @(negedge clk) begin : acc
      logic [29:0] ix;
      logic        e;
      logic [31:0] old;
      if (rst_n && req_valid && b0.req_ready) begin
         ix  = req_addr[31:2];
         e   = ix >= 30'd1024;
         old = e ? 32'h0 : model[ix[9:0]];
         q0.push_back({req_we, e, (e || req_we) ? 32'h0 : old});
         q1.push_back({req_we, e, e ? 32'h0 : old});
         if (req_we && !e)
            for (int i = 0; i < 4; i++)
               if (req_be[i]) model[ix[9:0]][8*i +: 8] = req_wdata[8*i +: 8];
      end
   end

   always @(negedge clk) begin : mon0
      exp_t e;
      if (rst_n && b0.rsp_valid && rsp_ready) begin
         n_chk++;
         if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL rsp0_unexpected: got %h expected no response", {b0.rsp_we, b0.rsp_err, b0.rsp_rdata});
         end else begin
            e = q0.pop_front();
            if ({b0.rsp_we, b0.rsp_err, b0.rsp_rdata} !== e) begin
               n_fail++;
               $display("FAIL rsp0_scoreboard: got we=%b err=%b d=%h expected we=%b err=%b d=%h",
                  b0.rsp_we, b0.rsp_err, b0.rsp_rdata, e.we, e.err, e.d);
            end
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (rst_n && b1.rsp_valid && rsp_ready) begin
         n_chk++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL rsp1_unexpected: got %h expected no response", {b1.rsp_we, b1.rsp_err, b1.rsp_rdata});
         end else begin
            e = q1.pop_front();
            if ({b1.rsp_we, b1.rsp_err, b1.rsp_rdata} !== e) begin
               n_fail++;
               $display("FAIL rsp1_scoreboard: got we=%b err=%b d=%h expected we=%b err=%b d=%h",
                  b1.rsp_we, b1.rsp_err, b1.rsp_rdata, e.we, e.err, e.d);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // presents a request and returns once it has been accepted; valid stays high
   task automatic drive(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output int waited);
      logic done;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_be    = be;
      req_wdata = wd;
      waited    = 0;
      done      = 1'b0;
      while (!done && waited < 20) begin
         @(negedge clk);
         done = b0.req_ready;
         step();
         if (!done) waited++;
      end
      n_chk++;
      if (!done) begin
         n_fail++;
         $display("FAIL drive_timeout: got no accept expected accept within 20 cycles, addr %h", a);
         req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
         step();
         n++;
      end
      n_chk++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_chk++;
      if ({b0.rsp_valid, b0.rsp_we, b0.rsp_err, b0.rsp_rdata, b1.rsp_valid} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b we=%b err=%b d=%h v1=%b expected all 0",
            b0.rsp_valid, b0.rsp_we, b0.rsp_err, b0.rsp_rdata, b1.rsp_valid);
      end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (b0.req_ready !== 1'b1 || b0.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0", b0.req_ready, b0.rsp_valid);
      end
      step();
   endtask

   task automatic test_basic();
      int w;
      rsp_ready = 1'b1;
      drive(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, w);
      req_valid = 1'b0;
      drain();
      drive(1'b0, 32'h10, 4'h0, 32'h0, w);
      req_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (b0.rsp_valid !== 1'b1 || b0.rsp_rdata !== 32'hDEADBEEF || b0.rsp_we !== 1'b0 || b0.rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_read: got v=%b d=%h we=%b err=%b expected v=1 d=deadbeef we=0 err=0",
            b0.rsp_valid, b0.rsp_rdata, b0.rsp_we, b0.rsp_err);
      end
      step();
      drain();
   endtask

   task automatic test_byte_lane();
      int w;
      drive(1'b1, 32'h12, 4'b0100, 32'h00AA0000, w);
      req_valid = 1'b0;
      drain();
      drive(1'b0, 32'h10, 4'h0, 32'h0, w);
      req_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (b0.rsp_rdata !== 32'hDEAABEEF) begin
         n_fail++;
         $display("FAIL byte_lane: got %h expected deaabeef", b0.rsp_rdata);
      end
      step();
      drain();
   endtask

   task automatic test_back_to_back();
      int w [4];
      drive(1'b1, 32'h00, 4'hF, 32'h0BADC0DE, w[0]);
      drive(1'b1, 32'h14, 4'hF, 32'hCAFEF00D, w[1]);
      drive(1'b1, 32'h20, 4'hF, 32'h11111111, w[2]);
      drive(1'b0, 32'h20, 4'h0, 32'h0, w[3]);
      req_valid = 1'b0;
      n_chk++;
      if (w[0] + w[1] + w[2] + w[3] != 0) begin
         n_fail++;
         $display("FAIL b2b_throughput: got %0d stall cycles expected 0", w[0] + w[1] + w[2] + w[3]);
      end
      @(negedge clk);
      n_chk++;
      if (b0.rsp_rdata !== 32'h11111111 || b0.rsp_we !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_read: got d=%h we=%b expected d=11111111 we=0", b0.rsp_rdata, b0.rsp_we);
      end
      step();
      drain();
   endtask

   task automatic test_backpressure();
      int w;
      rsp_ready = 1'b0;
      drive(1'b0, 32'h10, 4'h0, 32'h0, w);
      drive(1'b0, 32'h20, 4'h0, 32'h0, w);
      req_addr = 32'h14;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_chk++;
         if (b0.req_ready !== 1'b0 || b0.rsp_valid !== 1'b1 || b0.rsp_rdata !== 32'hDEAABEEF) begin
            n_fail++;
            $display("FAIL bp_hold: got ready=%b v=%b d=%h expected ready=0 v=1 d=deaabeef",
               b0.req_ready, b0.rsp_valid, b0.rsp_rdata);
         end
         step();
      end
      rsp_ready = 1'b1;
      drive(1'b0, 32'h14, 4'h0, 32'h0, w);
      req_valid = 1'b0;
      n_chk++;
      if (w != 1) begin
         n_fail++;
         $display("FAIL bp_third_accept: got %0d stall cycles expected 1", w);
      end
      @(negedge clk);
      n_chk++;
      if (b0.rsp_rdata !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL bp_third_data: got %h expected cafef00d", b0.rsp_rdata);
      end
      step();
      drain();
   endtask

   task automatic test_out_of_range();
      int w;
      drive(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, w);
      req_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (b0.rsp_err !== 1'b1 || b0.rsp_rdata !== 32'h0 || b0.rsp_we !== 1'b1 || b1.rsp_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL oor_write: got err=%b d=%h we=%b d1=%h expected err=1 d=0 we=1 d1=0",
            b0.rsp_err, b0.rsp_rdata, b0.rsp_we, b1.rsp_rdata);
      end
      step();
      drain();
      drive(1'b0, 32'h0, 4'h0, 32'h0, w);
      req_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (b0.rsp_rdata !== 32'h0BADC0DE || b0.rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_word0: got d=%h err=%b expected d=0badc0de err=0", b0.rsp_rdata, b0.rsp_err);
      end
      step();
      drain();
      drive(1'b0, 32'h1000, 4'h0, 32'h0, w);
      req_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (b0.rsp_err !== 1'b1 || b0.rsp_rdata !== 32'h0 || b0.rsp_we !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_read: got err=%b d=%h we=%b expected err=1 d=0 we=0", b0.rsp_err, b0.rsp_rdata, b0.rsp_we);
      end
      step();
      drain();
   endtask

   task automatic test_swap();
      int w;
      drive(1'b1, 32'h10, 4'hF, 32'h12345678, w);
      req_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (b1.rsp_rdata !== 32'hDEAABEEF || b1.rsp_we !== 1'b1 || b0.rsp_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL swap_write: got d1=%h we1=%b d0=%h expected d1=deaabeef we1=1 d0=0",
            b1.rsp_rdata, b1.rsp_we, b0.rsp_rdata);
      end
      step();
      drain();
      drive(1'b0, 32'h10, 4'h0, 32'h0, w);
      req_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (b1.rsp_rdata !== 32'h12345678 || b0.rsp_rdata !== 32'h12345678) begin
         n_fail++;
         $display("FAIL swap_read: got d1=%h d0=%h expected 12345678", b1.rsp_rdata, b0.rsp_rdata);
      end
      step();
      drain();
   endtask

   task automatic test_reset_mid();
      int w;
      rsp_ready = 1'b0;
      drive(1'b0, 32'h10, 4'h0, 32'h0, w);
      drive(1'b0, 32'h20, 4'h0, 32'h0, w);
      req_we    = 1'b1;
      req_addr  = 32'h10;
      req_be    = 4'hF;
      req_wdata = 32'hBAD0BAD0;
      @(negedge clk);
      n_chk++;
      if (b0.rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_pending: got v=%b expected 1", b0.rsp_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      q0.delete();
      q1.delete();
      n_chk++;
      if (b0.rsp_valid !== 1'b0 || b1.rsp_valid !== 1'b0 || b0.rsp_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid_async: got v0=%b v1=%b d=%h expected 0 0 0", b0.rsp_valid, b1.rsp_valid, b0.rsp_rdata);
      end
      step();
      step();
      req_valid = 1'b0;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      n_chk++;
      if (b0.req_ready !== 1'b1 || b0.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_release: got ready=%b v=%b expected ready=1 v=0", b0.req_ready, b0.rsp_valid);
      end
      step();
      drive(1'b0, 32'h10, 4'h0, 32'h0, w);
      req_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (b0.rsp_rdata !== 32'h12345678 || b1.rsp_rdata !== 32'h12345678) begin
         n_fail++;
         $display("FAIL rst_mid_retain: got d0=%h d1=%h expected 12345678", b0.rsp_rdata, b1.rsp_rdata);
      end
      step();
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_lane();
      test_back_to_back();
      test_backpressure();
      test_out_of_range();
      test_swap();
      test_reset_mid();
      n_chk++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL final_empty: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
